// File: rtl/inst_refill_writer.sv
// inst_refill_writer
//   Instruction-cache line refill engine. Accepts a miss address, issues one
//   burst read for the whole line, collects the returned beats into a line
//   buffer, writes the complete line into the data RAM in a single cycle and
//   then pulses done. The missed word is forwarded on crit_* as it arrives.
//
//   Build option: define REFILL_WRAP_BURST_EN to request a WRAP burst that
//   starts at the missed word (critical word first). Without it an INCR burst
//   from the line base is used.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   req_valid/req_ready/req_addr  refill request handshake and miss address
//   arvalid/arready/araddr/arlen/arburst  burst read request
//   rvalid/rready/rdata/rlast     read data beats
//   ram_en/ram_wen/ram_index/ram_wdata    data-RAM line write port
//   crit_valid/crit_data          missed word forward (one-cycle pulse)
//   done, busy                    completion pulse, engine not idle
module inst_refill_writer #(
  parameter int INDEX_W    = 7,
  parameter int LINE_WORDS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [31:0]             req_addr,
  output logic                    arvalid,
  input  logic                    arready,
  output logic [31:0]             araddr,
  output logic [7:0]              arlen,
  output logic [1:0]              arburst,
  input  logic                    rvalid,
  output logic                    rready,
  input  logic [31:0]             rdata,
  input  logic                    rlast,
  output logic                    ram_en,
  output logic [4*LINE_WORDS-1:0] ram_wen,
  output logic [INDEX_W-1:0]      ram_index,
  output logic [32*LINE_WORDS-1:0] ram_wdata,
  output logic                    crit_valid,
  output logic [31:0]             crit_data,
  output logic                    done,
  output logic                    busy
);

  localparam int SLOT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int CNT_W  = SLOT_W + 1;
  localparam logic [CNT_W-1:0] LW_C    = CNT_W'(LINE_WORDS);
  localparam logic [7:0]       ARLEN_C = 8'(LINE_WORDS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_AR    = 3'd1;
  localparam logic [2:0] S_RECV  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       state_q;
  logic [31:0]      addr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      line_q [LINE_WORDS];

  logic [CNT_W-1:0] start_w;
  logic [CNT_W-1:0] crit_slot;
  logic [CNT_W-1:0] slot_sum;
  logic [CNT_W-1:0] slot;
  logic [SLOT_W-1:0] slot_idx;
  logic [31:0]      araddr_w;
  logic [1:0]       arburst_w;
  logic             room;
  logic             beat;
  logic             unused_addr_bits;

  // Byte-offset bits never reach the bus or the RAM.
  assign unused_addr_bits = ^addr_q[1:0];

  assign crit_slot = CNT_W'(SLOT_W'(addr_q[4:2]));

`ifdef REFILL_WRAP_BURST_EN
  assign start_w   = crit_slot;
  assign araddr_w  = {addr_q[31:2], 2'b00};
  assign arburst_w = 2'b10;
`else
  assign start_w   = '0;
  assign araddr_w  = {addr_q[31:5], 5'b0};
  assign arburst_w = 2'b01;
`endif

  // Beat n of the burst lands in slot (start + n) mod LINE_WORDS; both terms
  // are below LINE_WORDS so one conditional subtract is enough.
  assign slot_sum = start_w + cnt_q;
  assign slot     = (slot_sum >= LW_C) ? (slot_sum - LW_C) : slot_sum;
  assign slot_idx = slot[SLOT_W-1:0];

  // Beats beyond a full line are still accepted but no longer stored.
  assign room = (cnt_q < LW_C);
  assign beat = (state_q == S_RECV) && rvalid;

  assign req_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign arvalid    = (state_q == S_AR);
  assign araddr     = (state_q == S_AR) ? araddr_w : '0;
  assign arlen      = (state_q == S_AR) ? ARLEN_C : '0;
  assign arburst    = (state_q == S_AR) ? arburst_w : '0;
  assign rready     = (state_q == S_RECV);
  assign ram_en     = (state_q == S_WRITE);
  assign ram_wen    = (state_q == S_WRITE) ? '1 : '0;
  assign ram_index  = (state_q == S_WRITE) ? addr_q[INDEX_W+4:5] : '0;
  assign done       = (state_q == S_DONE);
  assign crit_valid = beat && room && (slot == crit_slot);
  assign crit_data  = crit_valid ? rdata : '0;

  always_comb begin
    ram_wdata = '0;
    if (state_q == S_WRITE) begin
      for (int i = 0; i < LINE_WORDS; i++) begin
        ram_wdata[32*i +: 32] = line_q[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < LINE_WORDS; i++) begin
        line_q[i] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            cnt_q   <= '0;
            // Cleared so that words missing after an early rlast read as zero.
            for (int i = 0; i < LINE_WORDS; i++) begin
              line_q[i] <= '0;
            end
            state_q <= S_AR;
          end
        end
        S_AR: begin
          if (arready) begin
            state_q <= S_RECV;
          end
        end
        S_RECV: begin
          if (rvalid) begin
            if (room) begin
              line_q[slot_idx] <= rdata;
              cnt_q            <= cnt_q + CNT_W'(1);
            end
            if (rlast) begin
              state_q <= S_WRITE;
            end
          end
        end
        S_WRITE: state_q <= S_DONE;
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/inst_refill_writer.md
INST_REFILL_WRITER -- requirements
Module: inst_refill_writer

Interface
REQ-001 SHALL have parameter INDEX_W, default 7, giving the width of the data-RAM set index.
REQ-002 SHALL have parameter LINE_WORDS, default 8, giving the number of 32-bit words per line.
REQ-003 SHALL have port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst, input, 1, the asynchronous active-high reset.
REQ-005 SHALL have ports req_valid (input, 1) and req_ready (output, 1), the refill request handshake.
REQ-006 SHALL have port req_addr, input, 32, the miss address, captured when req_valid and req_ready are both high.
REQ-007 SHALL have ports arvalid (output, 1), arready (input, 1), araddr (output, 32), arlen (output, 8) and arburst (output, 2), the burst read request.
REQ-008 SHALL have ports rvalid (input, 1), rready (output, 1), rdata (input, 32) and rlast (input, 1), the read data beats.
REQ-009 SHALL have ports ram_en (output, 1), ram_wen (output, 4*LINE_WORDS), ram_index (output, INDEX_W) and ram_wdata (output, 32*LINE_WORDS), the data-RAM write port.
REQ-010 SHALL have ports crit_valid (output, 1) and crit_data (output, 32), which forward the missed word.
REQ-011 SHALL have ports done (output, 1), a one-cycle completion pulse, and busy (output, 1), high in every state except IDLE.

Function
REQ-012 SHALL implement the states IDLE, AR, RECV, WRITE and DONE.
REQ-013 IDLE: req_ready=1; on a request handshake SHALL capture req_addr, clear the line buffer and the beat counter, and go to AR.
REQ-014 AR: arvalid=1 and arlen=LINE_WORDS-1; arvalid and araddr SHALL stay stable until arready is high, and that cycle SHALL go to RECV.
REQ-015 RECV: rready=1; each beat with rvalid high SHALL be stored in word slot (start+beat) mod LINE_WORDS, and the beat counter SHALL increment.
REQ-016 A beat with rvalid and rlast both high SHALL be stored and SHALL go to WRITE.
REQ-017 Beats after LINE_WORDS beats without rlast SHALL be accepted and discarded until rlast.
REQ-018 If rlast arrives early, the unreceived words SHALL be written as zero.
REQ-019 WRITE lasts one cycle: ram_en=1, ram_wen all ones, ram_index=addr[INDEX_W+4:5], ram_wdata=buffer with word 0 in bits [31:0]; then go to DONE.
REQ-020 ram_en and ram_wen SHALL be 0 in every state other than WRITE.
REQ-021 DONE: done=1 for exactly one cycle, then go to IDLE.
REQ-022 A new request SHALL only be accepted in IDLE, giving a minimum spacing of 4 + LINE_WORDS cycles between acceptances.
REQ-023 crit_valid SHALL pulse for one cycle on the accepted beat carrying word addr[4:2], with crit_data equal to rdata in that cycle.

Reset
REQ-024 rst SHALL force IDLE asynchronously from any state, including mid-burst.
REQ-025 In reset, all outputs SHALL be 0 except req_ready, which SHALL be 1.
REQ-026 The line buffer, beat counter and captured address SHALL be cleared in reset.
REQ-027 A burst interrupted by reset is abandoned, and no RAM write SHALL occur for it.

Configuration
REQ-028 With macro REFILL_WRAP_BURST_EN defined: araddr={addr[31:2],2'b00}, arburst=2'b10 (WRAP), start=addr[4:2], so the critical word arrives on the first beat.
REQ-029 Without REFILL_WRAP_BURST_EN: araddr={addr[31:5],5'b0}, arburst=2'b01 (INCR), start=0.

Verification
REQ-030 Default build, request 0x0000_1F64, arready immediate, 8 consecutive beats 0x100..0x107 with rlast on beat 8 -> araddr=0x0000_1F60, arburst=01, arlen=7. Single ram_en cycle with ram_index=0x7B, ram_wen=0xFFFFFFFF and word0=0x100..word7=0x107. crit_valid on the 2nd beat with crit_data=0x101. done one cycle after the write.
REQ-031 WRAP build, same request -> araddr=0x0000_1F64, arburst=10, crit_valid on the 1st beat with crit_data=0x100, and that beat stored in slot 1.
REQ-032 Default build, rvalid toggling every other cycle and arready delayed 3 cycles -> same RAM image as REQ-030, arvalid and araddr stable while waiting, no extra ram_en cycles.
REQ-033 Default build, rlast on beat 5 -> words 5..7 of ram_wdata equal 0, and done is asserted.
REQ-034 Default build, rst asserted during beat 4 -> next cycle in IDLE, req_ready=1, no ram_en pulse. A new request then completes normally.
REQ-035 Default build, req_valid held high continuously -> the second request is accepted only after done, never during busy.
